// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing constants, state and flag types
package vga_timing_pkg;

  localparam int unsigned CNT_W = 11;

  localparam int unsigned VGA_X_RES         = 800;
  localparam int unsigned VGA_Y_RES         = 600;
  localparam int unsigned VGA_H_FRONT_PORCH = 40;
  localparam int unsigned VGA_H_SYNC        = 128;
  localparam int unsigned VGA_H_BACK_PORCH  = 88;
  localparam int unsigned VGA_V_FRONT_PORCH = 1;
  localparam int unsigned VGA_V_SYNC        = 4;
  localparam int unsigned VGA_V_BACK_PORCH  = 23;

  localparam int unsigned VGA_H_TOTAL =
    VGA_X_RES + VGA_H_FRONT_PORCH + VGA_H_SYNC + VGA_H_BACK_PORCH;
  localparam int unsigned VGA_V_TOTAL =
    VGA_Y_RES + VGA_V_FRONT_PORCH + VGA_V_SYNC + VGA_V_BACK_PORCH;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } dac_state_e;

  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } pix_flags_t;

  function automatic logic in_span(input logic [CNT_W-1:0] v,
                                   input int unsigned lo,
                                   input int unsigned len);
    int unsigned vv;
    vv = 32'(v);
    return (vv >= lo) && (vv < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// rtl/vga_timing_counter.sv - pixel/line counters with raw sync and active decode
module vga_timing_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned X_RES         = VGA_X_RES,
  parameter int unsigned Y_RES         = VGA_Y_RES,
  parameter int unsigned H_FRONT_PORCH = VGA_H_FRONT_PORCH,
  parameter int unsigned H_SYNC        = VGA_H_SYNC,
  parameter int unsigned H_BACK_PORCH  = VGA_H_BACK_PORCH,
  parameter int unsigned V_FRONT_PORCH = VGA_V_FRONT_PORCH,
  parameter int unsigned V_SYNC        = VGA_V_SYNC,
  parameter int unsigned V_BACK_PORCH  = VGA_V_BACK_PORCH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_last,
  output pix_flags_t       flags
);

  localparam int unsigned H_TOTAL = X_RES + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int unsigned V_TOTAL = Y_RES + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;

  // Counters sit at the origin whenever not running so RUN always starts at (0,0).
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (!run) begin
      x_d = '0;
      y_d = '0;
    end else if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
    end else begin
      x_d = x_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  always_comb begin
    flags        = '0;
    flags.active = (32'(x_q) < X_RES) && (32'(y_q) < Y_RES);
    flags.hsync  = in_span(x_q, X_RES + H_FRONT_PORCH, H_SYNC);
    flags.vsync  = in_span(y_q, Y_RES + V_FRONT_PORCH, V_SYNC);
  end

  assign x          = x_q;
  assign y          = y_q;
  assign frame_last = (x_q == H_LAST) && (y_q == V_LAST);

endmodule

// File: rtl/dac_output.sv
// rtl/dac_output.sv - VGA DAC output stage: FSM, FIFO pop, 2-stage pin pipeline, underflow
module dac_output
  import vga_timing_pkg::*;
#(
  parameter int unsigned X_RES         = VGA_X_RES,
  parameter int unsigned Y_RES         = VGA_Y_RES,
  parameter int unsigned H_FRONT_PORCH = VGA_H_FRONT_PORCH,
  parameter int unsigned H_SYNC        = VGA_H_SYNC,
  parameter int unsigned H_BACK_PORCH  = VGA_H_BACK_PORCH,
  parameter int unsigned V_FRONT_PORCH = VGA_V_FRONT_PORCH,
  parameter int unsigned V_SYNC        = VGA_V_SYNC,
  parameter int unsigned V_BACK_PORCH  = VGA_V_BACK_PORCH
) (
  input  logic             hw_pixel_clk,
  input  logic             hw_rst_n,
  input  logic             enable,
  input  logic [15:0]      fifo_read_data,
  input  logic             fifo_empty,
  output logic             fifo_read_request,
  output logic [15:0]      hw_rgb_out,
  output logic             hw_hsync_out,
  output logic             hw_vsync_out,
  output logic             hw_blank_n,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             underflow,
  output logic [15:0]      underflow_count
);

  dac_state_e  state_q, state_d;
  logic [1:0]  rst_sync_q, rst_sync_d;
  pix_flags_t  s1_flags_q, s1_flags_d;
  logic        s1_pop_q, s1_pop_d;
  logic [15:0] rgb_q, rgb_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        blank_n_q, blank_n_d;
  logic        underflow_q, underflow_d;
  logic [15:0] ucnt_q, ucnt_d;

  logic        running;
  logic        run_allowed;
  logic        frame_last;
  logic        px_active;
  logic        starve;
  pix_flags_t  raw_flags;

  vga_timing_counter #(
    .X_RES         (X_RES),
    .Y_RES         (Y_RES),
    .H_FRONT_PORCH (H_FRONT_PORCH),
    .H_SYNC        (H_SYNC),
    .H_BACK_PORCH  (H_BACK_PORCH),
    .V_FRONT_PORCH (V_FRONT_PORCH),
    .V_SYNC        (V_SYNC),
    .V_BACK_PORCH  (V_BACK_PORCH)
  ) u_counter (
    .clk        (hw_pixel_clk),
    .rst_n      (hw_rst_n),
    .run        (running),
    .x          (pixel_x),
    .y          (pixel_y),
    .frame_last (frame_last),
    .flags      (raw_flags)
  );

  assign running     = (state_q == ST_RUN);
  assign run_allowed = rst_sync_q[1];

  // Stage 0: pop request is purely combinational so data lands in stage 1.
  assign px_active         = running && raw_flags.active;
  assign fifo_read_request = px_active && !fifo_empty;
  assign starve            = px_active && fifo_empty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (run_allowed && enable && !fifo_empty) state_d = ST_RUN;
      ST_RUN:  if (frame_last && !enable)                state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rst_sync_d  = {rst_sync_q[0], 1'b1};
    s1_flags_d  = running ? raw_flags : '0;
    s1_pop_d    = fifo_read_request;
    // Only a pixel that was actually popped may drive colour; everything else is black.
    rgb_d       = s1_pop_q ? fifo_read_data : 16'h0000;
    hsync_d     = s1_flags_q.hsync;
    vsync_d     = s1_flags_q.vsync;
    blank_n_d   = s1_flags_q.active;
    underflow_d = underflow_q | starve;
    ucnt_d      = ucnt_q;
    if (starve && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge hw_pixel_clk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      state_q     <= ST_IDLE;
      rst_sync_q  <= '0;
      s1_flags_q  <= '0;
      s1_pop_q    <= 1'b0;
      rgb_q       <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      blank_n_q   <= 1'b0;
      underflow_q <= 1'b0;
      ucnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      rst_sync_q  <= rst_sync_d;
      s1_flags_q  <= s1_flags_d;
      s1_pop_q    <= s1_pop_d;
      rgb_q       <= rgb_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      blank_n_q   <= blank_n_d;
      underflow_q <= underflow_d;
      ucnt_q      <= ucnt_d;
    end
  end

  assign hw_rgb_out      = rgb_q;
  assign hw_hsync_out    = hsync_q;
  assign hw_vsync_out    = vsync_q;
  assign hw_blank_n      = blank_n_q;
  assign underflow       = underflow_q;
  assign underflow_count = ucnt_q;

endmodule

// File: tb/tb_dac_output.sv
// tb/tb_dac_output.sv - randomized self-checking bench for dac_output against a frame-level model
module tb_dac_output;

  localparam int unsigned XR  = 96;
  localparam int unsigned HFP = 1;
  localparam int unsigned HSW = 2;
  localparam int unsigned HBP = 1;
  localparam int unsigned YR  = 40;
  localparam int unsigned VFP = 1;
  localparam int unsigned VSW = 2;
  localparam int unsigned VBP = 1;
  localparam int unsigned HT    = XR + HFP + HSW + HBP;
  localparam int unsigned VT    = YR + VFP + VSW + VBP;
  localparam int unsigned FRAME = HT * VT;

  typedef struct packed {
    logic [15:0] rgb;
    logic        hs;
    logic        vs;
    logic        act;
  } pin_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] fifo_read_data = 16'h0;
  logic        fifo_empty = 1'b1;
  logic        fifo_read_request;
  logic [15:0] hw_rgb_out;
  logic        hw_hsync_out;
  logic        hw_vsync_out;
  logic        hw_blank_n;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic        underflow;
  logic [15:0] underflow_count;

  dac_output #(
    .X_RES(XR), .Y_RES(YR),
    .H_FRONT_PORCH(HFP), .H_SYNC(HSW), .H_BACK_PORCH(HBP),
    .V_FRONT_PORCH(VFP), .V_SYNC(VSW), .V_BACK_PORCH(VBP)
  ) dut (
    .hw_pixel_clk      (clk),
    .hw_rst_n          (rst_n),
    .enable            (enable),
    .fifo_read_data    (fifo_read_data),
    .fifo_empty        (fifo_empty),
    .fifo_read_request (fifo_read_request),
    .hw_rgb_out        (hw_rgb_out),
    .hw_hsync_out      (hw_hsync_out),
    .hw_vsync_out      (hw_vsync_out),
    .hw_blank_n        (hw_blank_n),
    .pixel_x           (pixel_x),
    .pixel_y           (pixel_y),
    .underflow         (underflow),
    .underflow_count   (underflow_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: running flag, cycle index within the frame, starved-pixel tally, edges since reset release.
  bit          m_run = 1'b0;
  int          m_t = 0;
  int          m_ucnt = 0;
  int          edges = 0;
  bit          ramp_mode = 1'b1;
  pin_t        h0 = '0;
  pin_t        h1 = '0;
  bit          pop_pending = 1'b0;
  logic [15:0] pop_val = 16'h0;
  int          cur_x = 0;
  int          cur_y = 0;
  logic [10:0] end_x = '0;
  logic [10:0] end_y = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    int          ex, ey;
    bit          act, hs, vs, req;
    logic [15:0] val;
    @(negedge clk);
    if (!rst_n) begin
      m_run  = 1'b0;
      m_t    = 0;
      m_ucnt = 0;
      edges  = 0;
      h0     = '0;
      h1     = '0;
    end
    ex  = m_run ? (m_t % HT) : 0;
    ey  = m_run ? (m_t / HT) : 0;
    act = m_run && (ex < XR) && (ey < YR);
    hs  = m_run && (ex >= XR + HFP) && (ex < XR + HFP + HSW);
    vs  = m_run && (ey >= YR + VFP) && (ey < YR + VFP + VSW);
    req = act && !fifo_empty;
    val = req ? (ramp_mode ? 16'(ex) : 16'($urandom)) : 16'h0;
    if (errors < 40) begin
      check_eq("pixel_x", 32'(pixel_x), 32'(ex));
      check_eq("pixel_y", 32'(pixel_y), 32'(ey));
      check_eq("read_request", 32'(fifo_read_request), 32'(req));
      check_eq("rgb", 32'(hw_rgb_out), 32'(h1.rgb));
      check_eq("hsync", 32'(hw_hsync_out), 32'(h1.hs));
      check_eq("vsync", 32'(hw_vsync_out), 32'(h1.vs));
      check_eq("blank_n", 32'(hw_blank_n), 32'(h1.act));
      check_eq("underflow", 32'(underflow), 32'(m_ucnt != 0));
      check_eq("underflow_count", 32'(underflow_count), 32'(m_ucnt));
    end
    h1 = h0;
    h0 = '{rgb: val, hs: hs, vs: vs, act: act};
    pop_pending = fifo_read_request;
    pop_val     = val;
    if (act && fifo_empty && m_ucnt < 65535) m_ucnt++;
    cur_x = ex;
    cur_y = ey;
    if (rst_n) begin
      if (!m_run) begin
        if (edges >= 2 && enable && !fifo_empty) begin
          m_run = 1'b1;
          m_t   = 0;
        end
      end else if (m_t == FRAME - 1) begin
        if (!enable) begin
          m_run = 1'b0;
          end_x = pixel_x;
          end_y = pixel_y;
        end
        m_t = 0;
      end else begin
        m_t++;
      end
    end
    @(posedge clk);
    if (rst_n) edges++;
    #1;
    fifo_read_data = pop_pending ? pop_val : 16'($urandom);
  endtask

  task automatic run_until(input int ty, input int tx, input int limit, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      step();
      hit = (cur_y == ty) && (cur_x == tx);
    end
    check_eq(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    repeat (3) step();
    #1 rst_n = 1'b1;
    enable     = 1'b1;
    fifo_empty = 1'b0;
    ramp_mode  = 1'b1;

    // Ramp lines, then a 5-pixel starvation burst mid-line.
    run_until(3, 30, FRAME, "reach_line3");
    fifo_empty = 1'b1;
    repeat (5) step();
    fifo_empty = 1'b0;
    repeat (3) step();
    check_eq("underflow_after_burst", 32'(underflow), 32'd1);
    check_eq("underflow_count_5", 32'(underflow_count), 32'd5);

    // Random data and random FIFO gaps, then drop enable mid-frame.
    ramp_mode = 1'b0;
    for (int i = 0; i < int'(FRAME) && cur_y != 20; i++) begin
      fifo_empty = ($urandom_range(0, 5) == 0);
      step();
    end
    enable = 1'b0;
    begin
      int n;
      n = 0;
      while (m_run && n < int'(FRAME)) begin
        fifo_empty = ($urandom_range(0, 5) == 0);
        step();
        n++;
      end
      check_eq("frame_completes", 32'(m_run), 32'd0);
    end
    check_eq("last_x_before_idle", 32'(end_x), 32'(HT - 1));
    check_eq("last_y_before_idle", 32'(end_y), 32'(VT - 1));
    fifo_empty = 1'b0;
    repeat (6) step();
    check_eq("idle_blank_n", 32'(hw_blank_n), 32'd0);
    check_eq("idle_request", 32'(fifo_read_request), 32'd0);
    check_eq("idle_pixel_x", 32'(pixel_x), 32'd0);

    // Restart, then asynchronous reset in the middle of a line.
    enable    = 1'b1;
    ramp_mode = 1'b1;
    run_until(1, 40, 2 * HT, "reach_reset_point");
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_pixel_x", 32'(pixel_x), 32'd0);
    check_eq("rst_pixel_y", 32'(pixel_y), 32'd0);
    check_eq("rst_request", 32'(fifo_read_request), 32'd0);
    check_eq("rst_rgb", 32'(hw_rgb_out), 32'd0);
    check_eq("rst_hsync", 32'(hw_hsync_out), 32'd0);
    check_eq("rst_vsync", 32'(hw_vsync_out), 32'd0);
    check_eq("rst_blank_n", 32'(hw_blank_n), 32'd0);
    check_eq("rst_underflow", 32'(underflow), 32'd0);
    check_eq("rst_underflow_count", 32'(underflow_count), 32'd0);
    repeat (3) step();
    #1 rst_n = 1'b1;
    run_until(1, 0, 2 * HT, "restart_after_reset");

    // Continuous starvation until the counter saturates.
    fifo_empty = 1'b1;
    for (int i = 0; i < 80000 && m_ucnt < 65535; i++) step();
    check_eq("saturation_reached", 32'(m_ucnt), 32'd65535);
    repeat (300) step();
    check_eq("underflow_count_sat", 32'(underflow_count), 32'h0000FFFF);
    check_eq("underflow_sat_flag", 32'(underflow), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
